mem_responder: RTL and testbench

MEM_RESPONDER -- requirements
Module: mem_responder

---
 rtl/mem_responder_pkg.sv | 20 ++
 rtl/mem_responder_mem_bank.sv | 23 ++
 rtl/mem_responder.sv | 164 ++++++++++++++++
 tb/tb_mem_responder.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/mem_responder_pkg.sv
// Shared types and constants for the latency-modelled memory responder:
// FSM state encoding, funct3 access-size codes and the wait-counter limit.
package mem_responder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  localparam logic [2:0] SZ_B  = 3'b000;
  localparam logic [2:0] SZ_H  = 3'b001;
  localparam logic [2:0] SZ_W  = 3'b010;
  localparam logic [2:0] SZ_BU = 3'b100;
  localparam logic [2:0] SZ_HU = 3'b101;

  localparam int LATENCY_MAX = 15;
  localparam int CNT_W       = 4;

endpackage

// File: rtl/mem_responder_mem_bank.sv
// Word-addressed storage built from four independent byte lanes, each with its
// own write enable. Reads are combinational; contents are never reset.
module mem_bank #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic [3:0]        lane_we,
  input  logic [ADDR_W-1:0] word_addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata
);

  for (genvar g = 0; g < 4; g++) begin : g_lane
    logic [7:0] lane_mem [2**ADDR_W];

    always_ff @(posedge clk) begin
      if (lane_we[g]) lane_mem[word_addr] <= wdata[8*g +: 8];
    end

    assign rdata[8*g +: 8] = lane_mem[word_addr];
  end

endmodule

// File: rtl/mem_responder.sv
// Single-outstanding memory responder: latches one request, waits LATENCY
// cycles, then performs a lane-masked store or aligned load with fault checks.
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int ADDR_W  = 10,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [31:0] addr,
  input  logic [31:0] data_i,
  input  logic [2:0]  mem_size,
  output logic [31:0] data_o,
  output logic        ready_o,
  output logic        err_o
);

  localparam logic [CNT_W-1:0] LAT_INIT = CNT_W'(LATENCY);

  // Handshake: a request is accepted on any clk edge where req_i=1 and the
  // FSM is IDLE; ready_o then pulses for one cycle LATENCY+1 edges later.
  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               we_q, we_d;
  logic [31:0]        addr_q, addr_d;
  logic [31:0]        wdata_q, wdata_d;
  logic [2:0]         size_q, size_d;
  logic [31:0]        data_q, data_d;
  logic               ready_q, ready_d;
  logic               err_q, err_d;

  logic               size_legal;
  logic               misaligned;
  logic               out_of_range;
  logic               fault;
  logic [3:0]         lane_mask;
  logic [31:0]        lane_wdata;
  logic [3:0]         lane_we;
  logic [31:0]        rdata;
  logic [31:0]        rshift;
  logic [31:0]        load_data;

  always_comb begin
    size_legal = 1'b0;
    case (size_q)
      SZ_B, SZ_H, SZ_W: size_legal = 1'b1;
      SZ_BU, SZ_HU:     size_legal = !we_q;
      default:          size_legal = 1'b0;
    endcase
    misaligned = ((size_q == SZ_H || size_q == SZ_HU) && addr_q[0]) ||
                 ((size_q == SZ_W) && (addr_q[1:0] != 2'b00));
    out_of_range = (addr_q >> (ADDR_W + 2)) != 32'd0;
    fault = !size_legal || misaligned || out_of_range;
  end

  // The low two size bits give the access width for both signed and unsigned codes.
  always_comb begin
    lane_mask  = 4'b1111;
    lane_wdata = wdata_q;
    case (size_q[1:0])
      2'b00: begin
        lane_mask  = 4'b0001 << addr_q[1:0];
        lane_wdata = {4{wdata_q[7:0]}};
      end
      2'b01: begin
        lane_mask  = addr_q[1] ? 4'b1100 : 4'b0011;
        lane_wdata = {2{wdata_q[15:0]}};
      end
      default: begin
        lane_mask  = 4'b1111;
        lane_wdata = wdata_q;
      end
    endcase
    lane_we = (state_q == ST_RESP && reset && we_q && !fault) ? lane_mask : 4'b0000;
  end

  always_comb begin
    rshift    = rdata >> {addr_q[1:0], 3'b000};
    load_data = rdata;
    case (size_q[1:0])
      2'b00:   load_data = {24'd0, rshift[7:0]};
      2'b01:   load_data = {16'd0, addr_q[1] ? rdata[31:16] : rdata[15:0]};
      default: load_data = rdata;
    endcase
  end

  mem_bank #(
    .ADDR_W(ADDR_W)
  ) u_bank (
    .clk      (clk),
    .lane_we  (lane_we),
    .word_addr(addr_q[ADDR_W+1:2]),
    .wdata    (lane_wdata),
    .rdata    (rdata)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    size_d  = size_q;
    data_d  = data_q;
    ready_d = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_i) begin
          we_d    = we_i;
          addr_d  = addr;
          wdata_d = data_i;
          size_d  = mem_size;
          cnt_d   = LAT_INIT;
          state_d = (LATENCY == 0) ? ST_RESP : ST_WAIT;
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q <= 1) state_d = ST_RESP;
      end
      ST_RESP: begin
        ready_d = 1'b1;
        err_d   = fault;
        if (fault)      data_d = 32'd0;
        else if (!we_q) data_d = load_data;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      size_q  <= SZ_W;
      data_q  <= '0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      size_q  <= size_d;
      data_q  <= data_d;
      ready_q <= ready_d;
      err_q   <= err_d;
    end
  end

  assign data_o  = data_q;
  assign ready_o = ready_q;
  assign err_o   = err_q;

endmodule

// File: tb/tb_mem_responder.sv
// Directed self-checking bench for mem_responder (ADDR_W=10, LATENCY=2).
module tb_mem_responder;

  logic        clk;
  logic        reset;
  logic        req_i;
  logic        we_i;
  logic [31:0] addr;
  logic [31:0] data_i;
  logic [2:0]  mem_size;
  logic [31:0] data_o;
  logic        ready_o;
  logic        err_o;

  int checks;
  int failures;
  logic [31:0] last_load;

  mem_responder #(.ADDR_W(10), .LATENCY(2)) dut (
    .clk     (clk),
    .reset   (reset),
    .req_i   (req_i),
    .we_i    (we_i),
    .addr    (addr),
    .data_i  (data_i),
    .mem_size(mem_size),
    .data_o  (data_o),
    .ready_o (ready_o),
    .err_o   (err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issues one request, then waits (bounded) for ready_o; lat = edges after acceptance, -1 on timeout.
  task automatic access(input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic [2:0] sz, output int lat, output logic e,
                        output logic [31:0] rd);
    @(negedge clk);
    req_i = 1'b1; we_i = w; addr = a; data_i = d; mem_size = sz;
    @(posedge clk); #1;
    req_i = 1'b0;
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (ready_o) begin
        lat = i;
        break;
      end
    end
    e  = err_o;
    rd = data_o;
  endtask

  task automatic test_reset();
    int lat;
    reset = 1'b0; req_i = 1'b1; we_i = 1'b0; addr = 32'h0000_1000;
    data_i = 32'd0; mem_size = 3'b010;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (ready_o !== 1'b0) begin failures++; $display("FAIL reset_ready: got %b expected 0", ready_o); end
    checks++; if (err_o !== 1'b0) begin failures++; $display("FAIL reset_err: got %b expected 0", err_o); end
    checks++; if (data_o !== 32'd0) begin failures++; $display("FAIL reset_data: got %h expected 00000000", data_o); end
    // req_i held through reset: first edge with reset=1 accepts the (faulting) load.
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1; req_i = 1'b0;
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (ready_o) begin lat = i; break; end
    end
    checks++; if (lat !== 3) begin failures++; $display("FAIL reset_first_accept_latency: got %0d expected 3", lat); end
    checks++; if (err_o !== 1'b1 || data_o !== 32'd0) begin failures++; $display("FAIL reset_first_accept_err: got err=%b data=%h expected err=1 data=00000000", err_o, data_o); end
  endtask

  task automatic test_store_load();
    int lat; logic e; logic [31:0] rd;
    access(1'b1, 32'h10, 32'hDEAD_BEEF, 3'b010, lat, e, rd);
    checks++; if (lat !== 3) begin failures++; $display("FAIL store_w_latency: got %0d expected 3", lat); end
    checks++; if (e !== 1'b0 || rd !== 32'd0) begin failures++; $display("FAIL store_w_resp: got err=%b data=%h expected err=0 data=00000000", e, rd); end
    access(1'b0, 32'h10, 32'd0, 3'b010, lat, e, rd);
    checks++; if (lat !== 3) begin failures++; $display("FAIL load_w_latency: got %0d expected 3", lat); end
    checks++; if (e !== 1'b0 || rd !== 32'hDEAD_BEEF) begin failures++; $display("FAIL load_w_data: got err=%b data=%h expected err=0 data=deadbeef", e, rd); end
    @(posedge clk); #1;
    checks++; if (ready_o !== 1'b0) begin failures++; $display("FAIL ready_one_cycle: got %b expected 0", ready_o); end
  endtask

  task automatic test_byte_lanes();
    int lat; logic e; logic [31:0] rd;
    access(1'b1, 32'h12, 32'h0000_0055, 3'b000, lat, e, rd);
    checks++; if (e !== 1'b0 || rd !== 32'hDEAD_BEEF) begin failures++; $display("FAIL store_b_resp: got err=%b data=%h expected err=0 data=deadbeef", e, rd); end
    access(1'b0, 32'h10, 32'd0, 3'b010, lat, e, rd);
    checks++; if (rd !== 32'hDE55_BEEF) begin failures++; $display("FAIL load_after_b: got %h expected de55beef", rd); end
    access(1'b0, 32'h13, 32'd0, 3'b100, lat, e, rd);
    checks++; if (e !== 1'b0 || rd !== 32'h0000_00DE) begin failures++; $display("FAIL load_bu_13: got err=%b data=%h expected err=0 data=000000de", e, rd); end
    access(1'b0, 32'h11, 32'd0, 3'b000, lat, e, rd);
    checks++; if (rd !== 32'h0000_00BE) begin failures++; $display("FAIL load_b_11: got %h expected 000000be", rd); end
    access(1'b0, 32'h12, 32'd0, 3'b001, lat, e, rd);
    checks++; if (e !== 1'b0 || rd !== 32'h0000_DE55) begin failures++; $display("FAIL load_h_12: got err=%b data=%h expected err=0 data=0000de55", e, rd); end
    access(1'b0, 32'h10, 32'd0, 3'b101, lat, e, rd);
    checks++; if (rd !== 32'h0000_BEEF) begin failures++; $display("FAIL load_hu_10: got %h expected 0000beef", rd); end
    access(1'b1, 32'h1E, 32'h0000_A1B2, 3'b001, lat, e, rd);
    access(1'b0, 32'h1C, 32'd0, 3'b010, lat, e, rd);
    checks++; if (rd[31:16] !== 16'hA1B2) begin failures++; $display("FAIL store_h_upper: got %h expected a1b2 in [31:16]", rd[31:16]); end
  endtask

  task automatic test_faults();
    int lat; logic e; logic [31:0] rd;
    access(1'b1, 32'h11, 32'h0000_1234, 3'b001, lat, e, rd);
    checks++; if (lat !== 3 || e !== 1'b1 || rd !== 32'd0) begin failures++; $display("FAIL fault_h_misaligned: got lat=%0d err=%b data=%h expected lat=3 err=1 data=00000000", lat, e, rd); end
    access(1'b0, 32'h10, 32'd0, 3'b010, lat, e, rd);
    checks++; if (e !== 1'b0 || rd !== 32'hDE55_BEEF) begin failures++; $display("FAIL no_write_after_h_fault: got err=%b data=%h expected err=0 data=de55beef", e, rd); end
    access(1'b0, 32'h0000_1000, 32'd0, 3'b010, lat, e, rd);
    checks++; if (e !== 1'b1 || rd !== 32'd0) begin failures++; $display("FAIL fault_out_of_range: got err=%b data=%h expected err=1 data=00000000", e, rd); end
    access(1'b1, 32'h10, 32'h0000_0000, 3'b100, lat, e, rd);
    checks++; if (e !== 1'b1) begin failures++; $display("FAIL fault_store_bu: got err=%b expected 1", e); end
    access(1'b0, 32'h12, 32'd0, 3'b010, lat, e, rd);
    checks++; if (e !== 1'b1) begin failures++; $display("FAIL fault_w_misaligned: got err=%b expected 1", e); end
    access(1'b0, 32'h10, 32'd0, 3'b011, lat, e, rd);
    checks++; if (e !== 1'b1) begin failures++; $display("FAIL fault_size_011: got err=%b expected 1", e); end
    access(1'b0, 32'h10, 32'd0, 3'b010, lat, e, rd);
    checks++; if (e !== 1'b0 || rd !== 32'hDE55_BEEF) begin failures++; $display("FAIL no_write_after_bu_store: got err=%b data=%h expected err=0 data=de55beef", e, rd); end
    last_load = 32'hDE55_BEEF;
  endtask

  // req_i held high for 16 edges; only edges 0,4,8,12 land in IDLE.
  task automatic test_back_to_back();
    int rdy_cnt;
    logic exp_rdy;
    logic [31:0] exp_d;
    rdy_cnt = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      req_i = 1'b1;
      case (i)
        0:  begin we_i = 1'b1; addr = 32'h20; data_i = 32'h1122_3344; mem_size = 3'b010; end
        4:  begin we_i = 1'b0; addr = 32'h20; data_i = 32'h0;         mem_size = 3'b010; end
        8:  begin we_i = 1'b1; addr = 32'h21; data_i = 32'h0000_00AA; mem_size = 3'b000; end
        12: begin we_i = 1'b0; addr = 32'h20; data_i = 32'h0;         mem_size = 3'b010; end
        default: begin we_i = 1'b1; addr = 32'h20; data_i = 32'hFFFF_FFFF; mem_size = 3'b010; end
      endcase
      @(posedge clk); #1;
      exp_rdy = ((i % 4) == 3);
      if (ready_o) rdy_cnt++;
      checks++; if (ready_o !== exp_rdy) begin failures++; $display("FAIL b2b_ready_edge%0d: got %b expected %b", i, ready_o, exp_rdy); end
      if (exp_rdy) begin
        case (i)
          3:       exp_d = last_load;
          7, 11:   exp_d = 32'h1122_3344;
          default: exp_d = 32'h1122_AA44;
        endcase
        checks++; if (data_o !== exp_d || err_o !== 1'b0) begin failures++; $display("FAIL b2b_data_edge%0d: got err=%b data=%h expected err=0 data=%h", i, err_o, data_o, exp_d); end
      end
    end
    @(negedge clk); req_i = 1'b0;
    checks++; if (rdy_cnt !== 4) begin failures++; $display("FAIL b2b_ready_count: got %0d expected 4", rdy_cnt); end
  endtask

  task automatic test_reset_abort();
    int lat; logic e; logic [31:0] rd;
    logic seen;
    // Abort during WAIT.
    @(negedge clk);
    req_i = 1'b1; we_i = 1'b1; addr = 32'h20; data_i = 32'h1234_5678; mem_size = 3'b010;
    @(posedge clk); #1; req_i = 1'b0;
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;
    checks++; if (ready_o !== 1'b0 || data_o !== 32'd0) begin failures++; $display("FAIL abort_wait_reset_outputs: got ready=%b data=%h expected ready=0 data=00000000", ready_o, data_o); end
    @(negedge clk); reset = 1'b1;
    seen = 1'b0;
    repeat (5) begin @(posedge clk); #1; if (ready_o) seen = 1'b1; end
    checks++; if (seen !== 1'b0) begin failures++; $display("FAIL abort_wait_no_ready: got %b expected 0", seen); end
    access(1'b0, 32'h20, 32'd0, 3'b010, lat, e, rd);
    checks++; if (rd !== 32'h1122_AA44) begin failures++; $display("FAIL abort_wait_no_write: got %h expected 1122aa44", rd); end
    // Abort on the RESP edge.
    @(negedge clk);
    req_i = 1'b1; we_i = 1'b1; addr = 32'h20; data_i = 32'h0BAD_F00D; mem_size = 3'b010;
    @(posedge clk); #1; req_i = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;
    checks++; if (ready_o !== 1'b0) begin failures++; $display("FAIL abort_resp_ready: got %b expected 0", ready_o); end
    @(negedge clk); reset = 1'b1;
    seen = 1'b0;
    repeat (4) begin @(posedge clk); #1; if (ready_o) seen = 1'b1; end
    checks++; if (seen !== 1'b0) begin failures++; $display("FAIL abort_resp_no_ready: got %b expected 0", seen); end
    access(1'b0, 32'h20, 32'd0, 3'b010, lat, e, rd);
    checks++; if (lat !== 3 || rd !== 32'h1122_AA44) begin failures++; $display("FAIL abort_resp_no_write: got lat=%0d data=%h expected lat=3 data=1122aa44", lat, rd); end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    last_load = 32'd0;
    test_reset();
    test_store_load();
    test_byte_lanes();
    test_faults();
    test_back_to_back();
    test_reset_abort();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
